// File: rtl/switch_event_pkg.sv
// Shared sizing helpers and reset values for the switch event capture block.
package switch_event_pkg;

    // Width of a switch index; a single switch still needs one bit.
    function automatic int unsigned IndexWidth(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Debounce counter width, sized to hold DebounceCycles.
    function automatic int unsigned CountWidth(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

    // Event word layout is {rise, index}.
    function automatic int unsigned EventWidth(input int unsigned width);
        return IndexWidth(width) + 1;
    endfunction

    localparam logic ResetLevel    = 1'b0;
    localparam logic ResetOverflow = 1'b0;
    localparam logic ResetPend     = 1'b0;

endpackage

// File: rtl/switch_event_capture_fifo.sv
// Small synchronous FIFO holding event words; head is read straight from storage.
module event_fifo
    import switch_event_pkg::*;
#(
    parameter int unsigned DataWidth = 4,
    parameter int unsigned Depth     = 4
) (
    input  logic                         clock0,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DataWidth-1:0]         push_data,
    input  logic                         pop,
    output logic [DataWidth-1:0]         head,
    output logic [$clog2(Depth+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic                 do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(Depth));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Storage write; cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < Depth; k++) mem_q[k] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/switch_event_capture.sv
// Synchronises and debounces raw switches, queues every debounced edge as an event.
module switch_event_capture
    import switch_event_pkg::*;
#(
    parameter int unsigned Width          = 8,
    parameter int unsigned DebounceCycles = 16,
    parameter int unsigned FifoDepth      = 4
) (
    input  logic                         clock0,
    input  logic                         reset,
    input  logic [Width-1:0]             switches,
    output logic [Width-1:0]             state,
    output logic                         event_valid,
    input  logic                         event_ready,
    output logic [IndexWidth(Width)-1:0] event_index,
    output logic                         event_rise,
    output logic                         overflow,
    input  logic                         overflow_clear
);

    localparam int unsigned IndexW = IndexWidth(Width);
    localparam int unsigned CountW = CountWidth(DebounceCycles);
    localparam int unsigned EventW = EventWidth(Width);
    localparam int unsigned FifoCntW = $clog2(FifoDepth + 1);

    logic [Width-1:0]    flip;
    logic [Width-1:0]    new_level;
    logic [Width-1:0]    pend_q, pend_d;
    logic [Width-1:0]    pend_rise_q, pend_rise_d;
    logic [Width-1:0]    consumed;
    logic                overflow_q, overflow_d, overflow_set;
    logic                found, sel_rise, push, pop;
    logic [IndexW-1:0]   sel_idx;
    logic [EventW-1:0]   push_data, head;
    logic [FifoCntW-1:0] fifo_count;
    logic                fifo_full, fifo_empty;

    for (genvar i = 0; i < Width; i++) begin : g_bit
        logic              sync1, sync2;
        logic              level_q;
        logic [CountW-1:0] cnt_q;
        logic              flip_now;

        // Two-flop synchroniser; sync1 feeds nothing but sync2.
        always_ff @(posedge clock0 or negedge reset) begin
            if (!reset) begin
                sync1 <= ResetLevel;
                sync2 <= ResetLevel;
            end else begin
                sync1 <= switches[i];
                sync2 <= sync1;
            end
        end

        // Accept a change only after DebounceCycles consecutive differing samples.
        assign flip_now = (sync2 != level_q) && (cnt_q == CountW'(DebounceCycles - 1));

        // Debounce counter and debounced level.
        always_ff @(posedge clock0 or negedge reset) begin
            if (!reset) begin
                level_q <= ResetLevel;
                cnt_q   <= '0;
            end else if (sync2 == level_q) begin
                cnt_q <= '0;
            end else if (flip_now) begin
                level_q <= ~level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign state[i]     = level_q;
        assign flip[i]      = flip_now;
        assign new_level[i] = ~level_q;
    end

    assign pop  = event_ready && !fifo_empty;
    assign push = found && (!fifo_full || pop);

    // Scanner: pick the lowest-index pending bit.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        sel_rise = 1'b0;
        consumed = '0;
        for (int i = 0; i < Width; i++) begin
            if (!found && pend_q[i]) begin
                found    = 1'b1;
                sel_idx  = IndexW'(i);
                sel_rise = pend_rise_q[i];
            end
        end
        if (push) consumed[sel_idx] = 1'b1;
    end

    assign push_data = {sel_rise, sel_idx};

    // Pending flags; a re-flip before the old edge was queued loses that edge.
    always_comb begin
        pend_d       = pend_q;
        pend_rise_d  = pend_rise_q;
        overflow_set = 1'b0;
        for (int i = 0; i < Width; i++) begin
            if (flip[i]) begin
                if (pend_q[i] && !consumed[i]) overflow_set = 1'b1;
                pend_d[i]      = 1'b1;
                pend_rise_d[i] = new_level[i];
            end else if (consumed[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        // Set beats clear when both happen together.
        if (overflow_set)        overflow_d = 1'b1;
        else if (overflow_clear) overflow_d = 1'b0;
        else                     overflow_d = overflow_q;
    end

    // Pending and overflow registers.
    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            pend_q      <= {Width{ResetPend}};
            pend_rise_q <= '0;
            overflow_q  <= ResetOverflow;
        end else begin
            pend_q      <= pend_d;
            pend_rise_q <= pend_rise_d;
            overflow_q  <= overflow_d;
        end
    end

    event_fifo #(
        .DataWidth (EventW),
        .Depth     (FifoDepth)
    ) u_fifo (
        .clock0    (clock0),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign event_valid = (fifo_count != '0);
    assign event_rise  = head[EventW-1];
    assign event_index = head[IndexW-1:0];
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_switch_event_capture.sv
// Self-checking bench: vector table plus hand sequences, events checked via a scoreboard queue.
module tb_switch_event_capture;

    logic       clock0 = 1'b0;
    logic       reset;
    logic [7:0] switches;
    logic [7:0] state;
    logic       event_valid;
    logic       event_ready;
    logic [2:0] event_index;
    logic       event_rise;
    logic       overflow;
    logic       overflow_clear;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];

    typedef struct {
        logic [7:0] sw;
        int         hold;
        logic [7:0] exp_state;
    } vec_t;

    vec_t vecs[6];

    switch_event_capture #(
        .Width          (8),
        .DebounceCycles (16),
        .FifoDepth      (4)
    ) dut (
        .clock0         (clock0),
        .reset          (reset),
        .switches       (switches),
        .state          (state),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_index    (event_index),
        .event_rise     (event_rise),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    always #5 clock0 = ~clock0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock0);
            #1;
        end
    endtask

    // Queue one expected event per changed bit, lowest index first.
    task automatic expect_diff(input logic [7:0] prev, input logic [7:0] next);
        for (int i = 0; i < 8; i++) begin
            if (prev[i] != next[i]) begin
                logic [2:0] idx;
                idx = 3'(i);
                exp_q.push_back({next[i], idx});
            end
        end
    endtask

    // Scoreboard: a handshake seen here pops on the following rising edge.
    always @(negedge clock0) begin
        if (reset && event_valid && event_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL event_unexpected: got idx=%0d rise=%0d, none expected",
                         event_index, event_rise);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if ({event_rise, event_index} !== e) begin
                    bad++;
                    $display("FAIL event_order: got idx=%0d rise=%0d want idx=%0d rise=%0d",
                             event_index, event_rise, e[2:0], e[3]);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{sw: 8'h28, hold: 15, exp_state: 8'h08};  // bit5 glitch, 15 cycles
        vecs[1] = '{sw: 8'h08, hold: 30, exp_state: 8'h08};
        vecs[2] = '{sw: 8'h89, hold: 30, exp_state: 8'h89};
        vecs[3] = '{sw: 8'h80, hold: 30, exp_state: 8'h80};
        vecs[4] = '{sw: 8'hFF, hold: 40, exp_state: 8'hFF};
        vecs[5] = '{sw: 8'h00, hold: 40, exp_state: 8'h00};

        reset          = 1'b0;
        switches       = 8'h00;
        event_ready    = 1'b1;
        overflow_clear = 1'b0;
        tick(3);
        check("reset_state", {24'h0, state}, 32'h0);
        check("reset_valid", {31'h0, event_valid}, 32'h0);
        check("reset_head", {28'h0, event_rise, event_index}, 32'h0);
        check("reset_overflow", {31'h0, overflow}, 32'h0);
        reset = 1'b1;

        // Clean step on bit 3: state follows on the 18th edge after first sample.
        switches = 8'h08;
        expect_diff(8'h00, 8'h08);
        tick(17);
        check("latency_before", {24'h0, state}, 32'h00);
        tick(1);
        check("latency_at", {24'h0, state}, 32'h08);
        tick(6);
        check("single_drained", {31'h0, event_valid}, 32'h0);

        // Vector table, consumer always ready.
        begin
            logic [7:0] prev;
            prev = 8'h08;
            for (int v = 0; v < 6; v++) begin
                switches = vecs[v].sw;
                expect_diff(prev, vecs[v].exp_state);
                prev = vecs[v].exp_state;
                tick(vecs[v].hold);
                check($sformatf("vec%0d_state", v), {24'h0, state}, {24'h0, vecs[v].exp_state});
                if (v == 0) check("glitch_overflow", {31'h0, overflow}, 32'h0);
            end
        end
        check("table_drained", exp_q.size(), 32'h0);
        check("table_overflow", {31'h0, overflow}, 32'h0);

        // Back-pressure: five simultaneous edges into a four-entry FIFO.
        event_ready = 1'b0;
        switches    = 8'h57;
        exp_q.push_back({1'b1, 3'd0});
        exp_q.push_back({1'b1, 3'd1});
        exp_q.push_back({1'b1, 3'd2});
        exp_q.push_back({1'b1, 3'd4});
        tick(30);
        check("full_valid", {31'h0, event_valid}, 32'h1);
        check("full_head", {28'h0, event_rise, event_index}, {28'h0, 1'b1, 3'd0});
        check("full_no_overflow", {31'h0, overflow}, 32'h0);

        // Bit 6 re-flips while its rise is still pending: edge lost.
        switches = 8'h17;
        tick(30);
        check("reflip_overflow", {31'h0, overflow}, 32'h1);
        check("reflip_state", {24'h0, state}, 32'h17);

        // Another lost edge on the same edge as a clear: set must win.
        switches = 8'h57;
        tick(17);
        check("pre_clash_overflow", {31'h0, overflow}, 32'h1);
        overflow_clear = 1'b1;
        tick(1);
        overflow_clear = 1'b0;
        check("clash_overflow", {31'h0, overflow}, 32'h1);
        check("clash_state", {24'h0, state}, 32'h57);
        overflow_clear = 1'b1;
        tick(1);
        overflow_clear = 1'b0;
        check("clear_overflow", {31'h0, overflow}, 32'h0);
        exp_q.push_back({1'b1, 3'd6});

        // One pop on a full FIFO while bit 6 waits: push and pop share the edge.
        event_ready = 1'b1;
        tick(1);
        event_ready = 1'b0;
        check("poppush_valid", {31'h0, event_valid}, 32'h1);
        check("poppush_head", {28'h0, event_rise, event_index}, {28'h0, 1'b1, 3'd1});
        tick(2);
        check("hold_head", {28'h0, event_rise, event_index}, {28'h0, 1'b1, 3'd1});
        event_ready = 1'b1;
        tick(10);
        check("full_drained", exp_q.size(), 32'h0);
        check("full_valid_low", {31'h0, event_valid}, 32'h0);

        // Return to all-low, then queue events and reset mid-operation.
        switches = 8'h00;
        expect_diff(8'h57, 8'h00);
        tick(40);
        check("falls_drained", exp_q.size(), 32'h0);
        event_ready = 1'b0;
        switches    = 8'h0E;
        tick(25);
        check("queued_valid", {31'h0, event_valid}, 32'h1);
        switches = 8'h0F;
        tick(5);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("async_valid", {31'h0, event_valid}, 32'h0);
        check("async_state", {24'h0, state}, 32'h0);
        check("async_overflow", {31'h0, overflow}, 32'h0);
        tick(2);
        reset = 1'b1;
        event_ready = 1'b1;
        expect_diff(8'h00, 8'h0F);
        tick(17);
        check("rerelease_before", {24'h0, state}, 32'h00);
        check("rerelease_no_event", {31'h0, event_valid}, 32'h0);
        tick(1);
        check("rerelease_at", {24'h0, state}, 32'h0F);
        tick(15);
        check("final_drained", exp_q.size(), 32'h0);
        check("final_overflow", {31'h0, overflow}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
